// File: rtl/cdc_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// cdc_fifo_wr_ctrl
//   Write-side controller of a dual-clock FIFO, clocked entirely by clk_19_3.
//   It accepts producer writes and drives the write port of the dual-port RAM.
//   It publishes a registered Gray write pointer to the clk_4_5 read side.
//   The read side's Gray pointer is synchronised back into this domain and
//   used to derive full, almost_full, wr_level and a sticky overflow flag.
//
// Ports
//   clk_19_3           in   write-domain clock, rising edge
//   reset_button       in   asynchronous active-low reset
//   wr_en / wr_data    in   producer write request and data
//   rd_ptr_gray_async  in   read-side Gray pointer, unsynchronised
//   overflow_clr       in   clears the sticky overflow flag
//   wr_ptr_gray        out  registered Gray write pointer for the read side
//   mem_we/waddr/wdata out  RAM write port (captured on the same edge)
//   full, almost_full  out  registered occupancy flags
//   wr_level           out  registered occupancy, 0 .. 2**ADDR_W
//   overflow           out  sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module cdc_fifo_wr_ctrl #(
    parameter int DATA_W      = 6,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 14
) (
    input  logic              clk_19_3,
    input  logic              reset_button,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   rd_ptr_gray_async,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int              PW     = ADDR_W + 1;
    localparam logic [PW-1:0]   AF_LVL = PW'(AF_THRESH);

    logic                             accept;
    logic [PW-1:0]                    wbin;
    logic [PW-1:0]                    wbin_next;
    logic [PW-1:0]                    gray_next;
    logic [PW-1:0]                    rq_sync;
    logic [PW-1:0]                    rd_bin_sync;
    logic [PW-1:0]                    level_next;
    logic [PW-1:0]                    full_cmp;
    logic [SYNC_STAGES-1:0][PW-1:0]   rq_pipe;

    // Writes are dropped while full, so the RAM and pointer never see them.
    assign accept    = wr_en & ~full;
    assign mem_we    = accept;
    assign mem_waddr = wbin[ADDR_W-1:0];
    assign mem_wdata = wr_data;

    assign wbin_next = wbin + {{ADDR_W{1'b0}}, accept};
    assign gray_next = wbin_next ^ (wbin_next >> 1);

    // Synchroniser output is the last stage of the shift chain.
    assign rq_sync = rq_pipe[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        rd_bin_sync = '0;
        for (int i = 0; i < PW; i++)
            rd_bin_sync[i] = ^(rq_sync >> i);
    end

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray that means the top two bits inverted, the rest equal.
    assign full_cmp   = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
    assign level_next = wbin_next - rd_bin_sync;

    // Read-pointer synchroniser: raw async input goes straight into stage 0.
    always_ff @(posedge clk_19_3 or negedge reset_button) begin
        if (!reset_button)
            rq_pipe <= '0;
        else
            rq_pipe <= {rq_pipe[SYNC_STAGES-2:0], rd_ptr_gray_async};
    end

    always_ff @(posedge clk_19_3 or negedge reset_button) begin
        if (!reset_button) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            // Published on the same edge the RAM captures the data.
            wr_ptr_gray <= gray_next;
            full        <= (gray_next == full_cmp);
            almost_full <= (level_next >= AF_LVL);
            wr_level    <= level_next;
            // Set takes priority over clear.
            if (wr_en & full)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cdc_fifo_wr_ctrl
//   Directed plus randomised bench for cdc_fifo_wr_ctrl. The reference model
//   tracks writes and reads as plain integer counts, a data queue and a
//   two-cycle delay of the read count, and derives all expected outputs
//   from those counts.
// ---------------------------------------------------------------------------
module tb_cdc_fifo_wr_ctrl;

    logic       clk_19_3 = 1'b0;
    logic       reset_button = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_data = '0;
    logic [4:0] rd_ptr_gray_async = '0;
    logic [4:0] wr_ptr_gray;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [5:0] mem_wdata;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    cdc_fifo_wr_ctrl #(
        .DATA_W(6), .ADDR_W(4), .SYNC_STAGES(2), .AF_THRESH(14)
    ) dut (
        .clk_19_3          (clk_19_3),
        .reset_button      (reset_button),
        .wr_en             (wr_en),
        .wr_data           (wr_data),
        .rd_ptr_gray_async (rd_ptr_gray_async),
        .wr_ptr_gray       (wr_ptr_gray),
        .mem_we            (mem_we),
        .mem_waddr         (mem_waddr),
        .mem_wdata         (mem_wdata),
        .full              (full),
        .almost_full       (almost_full),
        .wr_level          (wr_level),
        .overflow          (overflow),
        .overflow_clr      (overflow_clr)
    );

    always #5 clk_19_3 = ~clk_19_3;

    int nchk = 0;
    int nfail = 0;

    // Reference model state
    int         w_cnt, rd_cnt, s0, s1;
    logic       m_full, m_af, m_ovf;
    int         m_lvl;
    logic [5:0] q[$];
    logic [5:0] ram [16];
    logic       seen_wrap;

    function automatic logic [4:0] g5(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        w_cnt = 0; rd_cnt = 0; s0 = 0; s1 = 0;
        m_full = 0; m_af = 0; m_ovf = 0; m_lvl = 0;
        q.delete();
    endtask

    // Asserts reset between edges, checks the asynchronous clear, holds
    // through one edge and releases just after it.
    task automatic do_reset();
        reset_button = 1'b0;
        wr_en = 1'b0; overflow_clr = 1'b0; rd_ptr_gray_async = '0;
        #1;
        chk("rst_gray",  wr_ptr_gray, 0);
        chk("rst_full",  full, 0);
        chk("rst_af",    almost_full, 0);
        chk("rst_level", wr_level, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_we",    mem_we, 0);
        chk("rst_waddr", mem_waddr, 0);
        @(posedge clk_19_3);
        #1 reset_button = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, check the combinational write port, clock,
    // update the model, check the registered outputs.
    task automatic cycle(input logic we, input logic [5:0] d, input logic clr, input logic rd);
        logic       acc;
        logic [4:0] pg;
        wr_en = we; wr_data = d; overflow_clr = clr;
        if (rd) begin
            chk("rd_data", ram[rd_cnt % 16], q.pop_front());
            rd_cnt++;
            rd_ptr_gray_async = g5(rd_cnt);
        end
        #1;
        acc = we & ~m_full;
        chk("mem_we", mem_we, acc);
        if (acc) begin
            chk("mem_waddr", mem_waddr, w_cnt % 16);
            chk("mem_wdata", mem_wdata, d);
        end
        if (mem_we) ram[mem_waddr] = mem_wdata;
        pg = wr_ptr_gray;
        @(posedge clk_19_3);
        if (acc) begin
            w_cnt++;
            q.push_back(d);
        end
        if (we & m_full) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        // Flags at this edge see the read count from two edges back.
        m_lvl  = w_cnt - s1;
        s1     = s0;
        s0     = rd_cnt;
        m_full = (m_lvl == 16);
        m_af   = (m_lvl >= 14);
        #1;
        chk("wr_ptr_gray", wr_ptr_gray, g5(w_cnt));
        chk("gray_1bit",   $countones(pg ^ wr_ptr_gray), acc ? 1 : 0);
        chk("full",        full, m_full);
        chk("almost_full", almost_full, m_af);
        chk("wr_level",    wr_level, m_lvl);
        chk("overflow",    overflow, m_ovf);
        if (pg == 5'b10000 && wr_ptr_gray == 5'b00000) seen_wrap = 1'b1;
    endtask

    initial begin
        seen_wrap = 1'b0;
        model_reset();

        // 1. Reset
        do_reset();

        // 2. Fill to full with 0..15, no reads
        for (int i = 0; i < 16; i++) cycle(1'b1, 6'(i), 1'b0, 1'b0);
        chk("fill_full_gray", wr_ptr_gray, 5'b11000);

        // 3. Overflow, clear, set-wins
        cycle(1'b1, 6'h2A, 1'b0, 1'b0);
        cycle(1'b0, 6'h00, 1'b1, 1'b0);
        cycle(1'b1, 6'h15, 1'b1, 1'b0);
        chk("ovf_set_wins", overflow, 1'b1);
        cycle(1'b0, 6'h00, 1'b1, 1'b0);

        // 4. One read releases full three edges later
        cycle(1'b0, 6'h00, 1'b0, 1'b1);
        chk("rel_e1_full", full, 1'b1);
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        chk("rel_e2_full", full, 1'b1);
        cycle(1'b0, 6'h00, 1'b0, 1'b0);
        chk("rel_e3_full", full, 1'b0);
        chk("rel_level",   wr_level, 15);

        // Drain and let the synchroniser settle
        while (rd_cnt < w_cnt) cycle(1'b0, 6'h00, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 6'h00, 1'b0, 1'b0);

        // 5. Wrap-around: 40 writes, reader lagging by 4
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 6'($urandom), 1'b0, (w_cnt - rd_cnt) >= 4);
        chk("gray_wrap_seen", seen_wrap, 1'b1);

        // Randomised mix of writes, reads and overflow clears
        for (int i = 0; i < 150; i++)
            cycle(($urandom % 4) != 0, 6'($urandom), ($urandom % 8) == 0,
                  (rd_cnt < w_cnt) && (($urandom % 3) == 0));
        while (rd_cnt < w_cnt) cycle(1'b0, 6'h00, 1'b1, 1'b1);

        // 6. Mid-operation reset after 9 writes; next write goes to address 0
        repeat (3) cycle(1'b0, 6'h00, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 6'(i + 7), 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 6'h3C, 1'b0, 1'b0);
        chk("post_rst_gray", wr_ptr_gray, 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
